paddle_encoder_tx: RTL

Generates the single-bit, line-timed `PDL` paddle signal consumed by the ball-and-paddle game, from a quadrature rotary encoder. It is the transmitting end of the paddle interface. The game latches its current line number on every `HSYNC` rising edge while `PDL` is low. This block therefore holds `PDL` low from line 0 through the encoded position each frame, then high. It sits beside the game on the same board, fed by the game's `HSYNC`/`VSYNC` outputs.

---
 rtl/paddle_encoder_tx_pkg.sv | 51 +++++
 rtl/paddle_encoder_tx_quad_decoder.sv | 60 ++++++
 rtl/paddle_encoder_tx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/paddle_encoder_tx_pkg.sv
// Shared constants and helpers for the paddle transmitter: frame timing that
// matches the game's vertical raster, paddle row limits and encoder filtering.
package paddle_encoder_tx_pkg;

    // Vertical raster of the game (lines)
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd9;
    localparam logic [9:0] V_PULSE  = 10'd2;
    localparam logic [9:0] V_BP     = 10'd29;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_PULSE + V_BP;   // 520
    localparam logic [9:0] VSYNC_END_LINE = V_ACTIVE + V_FP + V_PULSE;    // 491

    // Lines without a VSYNC fall before frame timing is considered lost
    localparam logic [10:0] WDOG_LINES = {V_TOTAL, 1'b0};                  // 1040

    // Paddle row limits and encoder behaviour
    localparam logic [9:0] POS_MIN  = 10'd232;
    localparam logic [9:0] POS_MAX  = 10'd463;
    localparam logic [9:0] POS_INIT = 10'd348;
    localparam logic [3:0] STEP     = 4'd2;
    localparam logic [7:0] DEBOUNCE = 8'd48;

    // Frame tracker states
    typedef enum logic {
        TRK_SEARCH = 1'b0,
        TRK_TRACK  = 1'b1
    } trk_state_t;

    // Move the position one encoder step, clamped to the paddle row limits
    function automatic logic [9:0] pos_step(input logic [9:0] cur, input logic up);
        logic [10:0] sum;
        sum = {1'b0, cur} + {7'd0, STEP};
        if (up) begin
            return (sum > {1'b0, POS_MAX}) ? POS_MAX : sum[9:0];
        end
        return (cur < POS_MIN + {6'd0, STEP}) ? POS_MIN : cur - {6'd0, STEP};
    endfunction

    // True when {a,b} moves one place forward along 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic gray_fwd(input logic [1:0] from, input logic [1:0] to);
        logic fwd;
        case (from)
            2'b00:   fwd = (to == 2'b01);
            2'b01:   fwd = (to == 2'b11);
            2'b11:   fwd = (to == 2'b10);
            default: fwd = (to == 2'b00);
        endcase
        return fwd;
    endfunction

endpackage

// File: rtl/paddle_encoder_tx_quad_decoder.sv
// Quadrature front end: 2-FF synchronizers, per-phase debounce and Gray-step
// decode. Emits one-cycle step_up / step_dn / err strobes.
module quad_decoder
    import paddle_encoder_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic enc_a,
    input  logic enc_b,
    output logic step_up,
    output logic step_dn,
    output logic err
);

    // Bit 1 is phase A, bit 0 is phase B
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] raw_last;
    logic [1:0] acc;
    logic [1:0] acc_prev;
    logic [7:0] cnt [2];
    logic [1:0] changed;

    // Synchronize the phases, restart a phase's stability count on every raw
    // change and accept its value once it has been stable DEBOUNCE cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 2'b00;
            sync2    <= 2'b00;
            raw_last <= 2'b00;
            acc      <= 2'b00;
            acc_prev <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= DEBOUNCE;
            end
        end else begin
            sync1    <= {enc_a, enc_b};
            sync2    <= sync1;
            acc_prev <= acc;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != raw_last[i]) begin
                    raw_last[i] <= sync2[i];
                    cnt[i]      <= 8'd1;
                end else if (cnt[i] != DEBOUNCE) begin
                    cnt[i] <= cnt[i] + 8'd1;
                    if (cnt[i] == DEBOUNCE - 8'd1) begin
                        acc[i] <= raw_last[i];
                    end
                end
            end
        end
    end

    // A single-phase change is a step; both phases changing together is illegal
    assign changed = acc ^ acc_prev;
    assign err     = &changed;
    assign step_up = (changed != 2'b00) && !err &&  gray_fwd(acc_prev, acc);
    assign step_dn = (changed != 2'b00) && !err && !gray_fwd(acc_prev, acc);

endmodule

// File: rtl/paddle_encoder_tx.sv
// Paddle transmitter: turns encoder motion into a clamped position and drives
// PDL low from line 0 through the position captured at each VSYNC fall.
module paddle_encoder_tx
    import paddle_encoder_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       enc_a,
    input  logic       enc_b,
    output logic       pdl,
    output logic [9:0] pos,
    output logic       locked,
    output logic       frame,
    output logic [7:0] enc_err,
    output trk_state_t dbg_state
);

    logic        hs_s1, hs_s2, hs_d;
    logic        vs_s1, vs_s2, vs_d;
    logic        hs_rise, vs_fall;
    logic        step_up, step_dn, err;
    logic        wdog_expire;
    logic [9:0]  line_cnt;
    logic [9:0]  pos_frame;
    logic [10:0] wdog;
    trk_state_t  state, state_nxt;

    quad_decoder u_quad (
        .clk     (clk),
        .rst     (rst),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .step_up (step_up),
        .step_dn (step_dn),
        .err     (err)
    );

    // Two-stage synchronizers plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_s1 <= 1'b0;
            hs_s2 <= 1'b0;
            hs_d  <= 1'b0;
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            hs_s1 <= hsync;
            hs_s2 <= hs_s1;
            hs_d  <= hs_s2;
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            vs_d  <= vs_s2;
        end
    end

    assign hs_rise     = hs_s2 & ~hs_d;
    assign vs_fall     = ~vs_s2 & vs_d;
    // A VSYNC fall in the same cycle swallows the HSYNC edge
    assign wdog_expire = hs_rise && !vs_fall && (wdog == WDOG_LINES - 11'd1);

    // Frame tracker state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TRK_SEARCH;
        else     state <= state_nxt;
    end

    // Frame tracker next state: lock on VSYNC fall, drop on watchdog expiry
    always_comb begin
        state_nxt = state;
        case (state)
            TRK_SEARCH: if (vs_fall) state_nxt = TRK_TRACK;
            TRK_TRACK:  if (!vs_fall && wdog_expire) state_nxt = TRK_SEARCH;
            default:    state_nxt = TRK_SEARCH;
        endcase
    end

    assign locked    = (state == TRK_TRACK);
    assign dbg_state = state;

    // Line counter, watchdog, frame capture and strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_cnt  <= 10'd0;
            wdog      <= 11'd0;
            pos_frame <= POS_INIT;
            frame     <= 1'b0;
        end else begin
            frame <= vs_fall;
            if (vs_fall) begin
                line_cnt  <= VSYNC_END_LINE;
                wdog      <= 11'd0;
                pos_frame <= pos;
            end else if (hs_rise) begin
                line_cnt <= (line_cnt == V_TOTAL - 10'd1) ? 10'd0 : line_cnt + 10'd1;
                if (state == TRK_TRACK && wdog != WDOG_LINES) begin
                    wdog <= wdog + 11'd1;
                end
            end
        end
    end

    // Clamped position and saturating illegal-transition counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos     <= POS_INIT;
            enc_err <= 8'd0;
        end else begin
            if (step_up)      pos <= pos_step(pos, 1'b1);
            else if (step_dn) pos <= pos_step(pos, 1'b0);
            if (err && enc_err != 8'hFF) enc_err <= enc_err + 8'd1;
        end
    end

    // Registered paddle line: low only while locked and at/before the position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pdl <= 1'b1;
        else     pdl <= !(locked && (line_cnt <= pos_frame));
    end

endmodule
